// File: rtl/voxel_projector.sv
// voxel_projector: orthographic 1-bit voxel renderer, front-most hit per pixel; optional depth shading via VOXEL_DEPTH_SHADE_EN.
module voxel_projector #(
  parameter int DIM_B = 3,
  parameter int STRIDE_B = 5,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8,
  parameter int FB_BASE = 0,
  parameter logic [DATA_W-1:0] FG_COLOR = 8'hFF,
  parameter logic [DATA_W-1:0] BG_COLOR = 8'h00,
  parameter int SHADE_STEP = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        view_axis,
  input  logic              vox_we,
  input  logic [DIM_B-1:0]  vox_wx,
  input  logic [DIM_B-1:0]  vox_wy,
  input  logic [DIM_B-1:0]  vox_wz,
  input  logic              vox_wd,
  output logic              busy,
  output logic              done,
  output logic              fb_valid,
  input  logic              fb_ready,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [DATA_W-1:0] fb_data
);
  localparam int N = 1 << DIM_B;
  typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;
  state_t state, state_n;
  logic [N*N*N-1:0] vox;
  logic [1:0] axis;
  logic [DIM_B-1:0] u, v, d, x, y, z;
  logic hit, last_d, last_px;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] hit_color;
  // (u,v,d) -> (x,y,z) for the latched axis
  always_comb begin
    x = axis == 2'd1 ? d : u;
    y = axis == 2'd2 ? d : v;
    z = axis == 2'd1 ? u : axis == 2'd2 ? v : d;
  end
  assign hit = vox[{z, y, x}];
  assign last_d = &d;
  assign last_px = &u && &v;
  assign addr = ADDR_W'(FB_BASE + (int'(v) << STRIDE_B) + int'(u));
`ifdef VOXEL_DEPTH_SHADE_EN
  localparam int SW = DATA_W + DIM_B;
  logic [SW-1:0] shade;
  assign shade = SW'(d) * SW'(SHADE_STEP);
  assign hit_color = shade > SW'(FG_COLOR) ? '0 : DATA_W'(SW'(FG_COLOR) - shade);
`else
  assign hit_color = FG_COLOR;
`endif
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign fb_valid = state == EMIT;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = start ? SCAN : IDLE;
      SCAN: state_n = hit || last_d ? EMIT : SCAN;
      EMIT: state_n = !fb_ready ? EMIT : last_px ? DONE : SCAN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) vox <= '0;
    else if (vox_we && state == IDLE) vox[{vox_wz, vox_wy, vox_wx}] <= vox_wd;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      axis <= '0;
      u <= '0;
      v <= '0;
      d <= '0;
      fb_addr <= '0;
      fb_data <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          axis <= view_axis == 2'd3 ? 2'd0 : view_axis;
          u <= '0;
          v <= '0;
          d <= '0;
        end
        SCAN: if (hit || last_d) begin
          fb_data <= hit ? hit_color : BG_COLOR;
          fb_addr <= addr;
        end else d <= d + 1'b1;
        EMIT: if (fb_ready) begin
          d <= '0;
          u <= u + 1'b1;
          if (&u) v <= v + 1'b1;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_voxel_projector.sv
// tb_voxel_projector: randomized and directed renders checked against a volume-scanning reference model.
module tb_voxel_projector;
  localparam int N = 8, STRIDE_B = 5, ADDR_W = 12;
  localparam int FB_BASE = 0, FG = 8'hFF, BG = 8'h00, STEP = 16;
  logic clk = 0, reset = 1, start = 0, vox_we = 0, vox_wd = 0, fb_ready = 0;
  logic [1:0] view_axis = 0;
  logic [2:0] vox_wx = 0, vox_wy = 0, vox_wz = 0;
  logic busy, done, fb_valid;
  logic [11:0] fb_addr;
  logic [7:0] fb_data;
  bit vol[N][N][N];
  int total = 0, bad = 0;

  voxel_projector dut (
    .clk(clk), .reset(reset), .start(start), .view_axis(view_axis),
    .vox_we(vox_we), .vox_wx(vox_wx), .vox_wy(vox_wy), .vox_wz(vox_wz), .vox_wd(vox_wd),
    .busy(busy), .done(done), .fb_valid(fb_valid), .fb_ready(fb_ready),
    .fb_addr(fb_addr), .fb_data(fb_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int hit_val(input int dep);
`ifdef VOXEL_DEPTH_SHADE_EN
    int p = dep * STEP;
    return p > FG ? 0 : FG - p;
`else
    return FG;
`endif
  endfunction

  // Look through the volume along the chosen axis; front-most set voxel wins.
  task automatic pixel(input int axis, input int u, input int v, output int data, output int cost);
    int a = axis == 3 ? 0 : axis;
    for (int dep = 0; dep < N; dep++) begin
      int x = a == 1 ? dep : u;
      int y = a == 2 ? dep : v;
      int z = a == 1 ? u : a == 2 ? v : dep;
      if (vol[x][y][z]) begin
        data = hit_val(dep);
        cost = dep + 2;
        return;
      end
    end
    data = BG;
    cost = N + 1;
  endtask

  task automatic wr(input int x, input int y, input int z, input bit val);
    @(negedge clk);
    vox_we = 1; vox_wx = 3'(x); vox_wy = 3'(y); vox_wz = 3'(z); vox_wd = val;
    @(negedge clk);
    vox_we = 0;
    vol[x][y][z] = val;
  endtask

  task automatic render(input int axis, input int rdy_pct, input bit stall, input bit poke, input int abort_px);
    int exp_addr[$], exp_data[$];
    int cyc_exp = 1, got = 0, cyc = 0, stall_left = stall ? 10 : 0;
    bit seen_done = 0, prev_v = 0;
    logic [11:0] pa = 0;
    logic [7:0] pd = 0;
    for (int v = 0; v < N; v++)
      for (int u = 0; u < N; u++) begin
        int dt, c;
        pixel(axis, u, v, dt, c);
        exp_addr.push_back((FB_BASE + v * (1 << STRIDE_B) + u) % (1 << ADDR_W));
        exp_data.push_back(dt);
        cyc_exp += c;
      end
    @(negedge clk);
    start = 1; view_axis = 2'(axis);
    @(negedge clk);
    start = 0;
    while (!seen_done && cyc < 5000) begin
      cyc++;
      if (cyc > 1) @(negedge clk);
      if (cyc == 1) chk("busy_rise", busy, 1);
      if (poke && cyc == 30) begin
        start = 1; vox_we = 1; vox_wx = 0; vox_wy = 0; vox_wz = 0; vox_wd = 1;
      end else if (poke && cyc == 31) begin
        start = 0; vox_we = 0;
      end
      if (abort_px >= 0 && got == abort_px && fb_valid) begin
        reset = 1;
        #1;
        chk("abort_valid", fb_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_addr", fb_addr, 0);
        foreach (vol[i, j, k]) vol[i][j][k] = 0;
        fb_ready = 0;
        @(negedge clk);
        reset = 0;
        return;
      end
      if (stall_left > 0 && fb_valid) begin
        fb_ready = 0;
        stall_left--;
      end else fb_ready = $urandom_range(99) < rdy_pct;
      if (prev_v) begin
        chk("hold_valid", fb_valid, 1);
        chk("hold_addr", fb_addr, pa);
        chk("hold_data", fb_data, pd);
      end
      if (done) begin
        seen_done = 1;
        chk("done_count", got, N * N);
        chk("done_busy", busy, 1);
        if (rdy_pct == 100 && !stall) chk("done_cycle", cyc, cyc_exp);
      end
      if (fb_valid && fb_ready) begin
        if (got < N * N) begin
          chk($sformatf("addr[%0d]", got), fb_addr, exp_addr[got]);
          chk($sformatf("data[%0d]", got), fb_data, exp_data[got]);
        end else chk("extra_write", got, N * N - 1);
        got++;
        prev_v = 0;
      end else begin
        prev_v = fb_valid;
        pa = fb_addr;
        pd = fb_data;
      end
    end
    if (!seen_done) chk("timeout", 0, 1);
    fb_ready = 0;
    @(negedge clk);
    chk("end_busy", busy, 0);
    chk("end_done", done, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", fb_valid, 0);
    chk("rst_addr", fb_addr, 0);
    chk("rst_data", fb_data, 0);
    reset = 0;
    wr(2, 3, 5, 1);
    render(0, 100, 0, 0, -1);
    render(1, 100, 0, 0, -1);
    render(3, 100, 0, 0, -1);
    wr(2, 3, 5, 0);
    wr(4, 4, 1, 1);
    wr(4, 4, 6, 1);
    render(0, 100, 0, 0, -1);
    render(0, 100, 1, 0, -1);
    render(2, 100, 0, 1, -1);
    render(0, 100, 0, 0, -1);
    render(0, 100, 0, 0, 19);
    render(0, 100, 0, 0, -1);
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 24; k++)
        wr($urandom_range(N - 1), $urandom_range(N - 1), $urandom_range(N - 1), $urandom_range(3) != 0);
      render($urandom_range(3), r % 2 ? 60 : 100, 0, 0, -1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/voxel_projector.md
Name: voxel_projector

Overview:
- Parametrised orthographic voxel renderer; next generation of the fixed 8x8x8 voxel engine.
- Holds a cubic 1-bit voxel volume of N=2^DIM_B per side, loadable through a write port.
- On start, projects the volume along a selectable axis and emits one framebuffer write per output pixel through a valid/ready port into the frame RAM writer.
- Per pixel, the front-most set voxel wins. Empty columns produce background.

Parameters:
- DIM_B, 3, log2 of cube side N (N=8 default).
- STRIDE_B, 5, log2 of framebuffer row stride in pixels; must be >= DIM_B.
- ADDR_W, 12, framebuffer address width.
- DATA_W, 8, pixel width.
- FB_BASE, 0, framebuffer base address of the projected image.
- FG_COLOR, 8'hFF, hit pixel value.
- BG_COLOR, 8'h00, empty-column pixel value.
- SHADE_STEP, 16, per-depth decrement; used only with VOXEL_DEPTH_SHADE_EN.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle render request; sampled only in IDLE.
- view_axis  in  2  projection axis, latched at start: 0=along z, 1=along x, 2=along y, 3 treated as 0.
- vox_we  in  1  voxel write strobe.
- vox_wx / vox_wy / vox_wz  in  DIM_B each  voxel write coordinate.
- vox_wd  in  1  voxel write value.
- busy  out  1  high from the cycle after an accepted start until DONE completes.
- done  out  1  one-cycle pulse marking completion.
- fb_valid  out  1  framebuffer write request.
- fb_ready  in  1  framebuffer write accept.
- fb_addr  out  ADDR_W  pixel address.
- fb_data  out  DATA_W  pixel value.

Behaviour:
- Reset (async): all voxels 0, state IDLE, busy=0, done=0, fb_valid=0, fb_addr=0, fb_data=0, internal u/v/d counters 0.
- Voxel store: register array of N^3 bits with combinational read.
- vox_we is honoured only while busy=0; writes during busy are dropped.
- Axis mapping, with (u,v) the image pixel and d the depth (d=0 is front):
  - axis 0: u=x, v=y, d=z.
  - axis 1: u=z, v=y, d=x.
  - axis 2: u=x, v=z, d=y.
- Pixel address = (FB_BASE + v*2^STRIDE_B + u) truncated to ADDR_W, with silent wrap.
- FSM: IDLE -> SCAN -> EMIT -> (SCAN | DONE) -> IDLE.
  - IDLE: on start=1, latch view_axis, clear u, v, d, go to SCAN. busy rises the next cycle.
  - SCAN: read one voxel per cycle at (u,v,d).
    - On hit: register fb_data=FG_COLOR and go to EMIT.
    - Else if d==N-1: register fb_data=BG_COLOR and go to EMIT.
    - Else: d+1 (early termination on the first hit).
  - EMIT: fb_valid=1, with fb_addr and fb_data held stable until fb_valid&fb_ready.
    - On handshake: d=0, advance u; u wraps to 0 with v+1.
    - Go to SCAN, or to DONE if (u,v) was (N-1,N-1).
  - DONE: done=1 and busy=1 for exactly one cycle, then IDLE with busy=0.
- Pixel order: u fastest, then v. Exactly N^2 writes per render, no pixel skipped or repeated.
- Cycle cost with fb_ready held high: a pixel with hit at depth d costs d+2 cycles; an empty pixel costs N+1 cycles.
- start while busy is ignored and never queued.
- Reset mid-render aborts immediately: fb_valid drops asynchronously; no done pulse.
- fb_valid never deasserts without a handshake except by reset.

Optional Feature:
- VOXEL_DEPTH_SHADE_EN defined: hit pixel value = FG_COLOR - d*SHADE_STEP, saturating at 0. Arithmetic is done at DATA_W+DIM_B bits before clamping.
- Not defined: hit pixel value = FG_COLOR. BG_COLOR behaviour is unchanged in both cases.

Test Plan:
- Voxel (2,3,5), axis 0, fb_ready=1, feature off -> 64 writes; only addr 98 carries 8'hFF, all others 8'h00; done pulses 575 cycles after the start cycle.
- Same voxel, axis 1, VOXEL_DEPTH_SHADE_EN -> addr 101 (u=5, v=3, d=2) = 8'hDF; the other 63 writes = 8'h00.
- Voxels (4,4,1) and (4,4,6), axis 0, shade on -> addr 132 written once with 8'hEF; the z=6 voxel is occluded.
- fb_ready low 10 cycles during the first EMIT -> fb_valid, fb_addr and fb_data stable throughout; the sequence resumes with no lost or duplicated pixels.
- start pulse and vox_we=1 at (0,0,0) mid-render -> render count stays 64; the voxel remains 0 on the next render.
- reset asserted during the 20th pixel -> fb_valid, busy and done go 0 at once; all voxels read back 0; a new start renders 64 BG writes.
